// File: rtl/control_contador.sv
// control_contador
//   Turns two debounced button levels into single-cycle step commands for the
//   4-bit up/down counter. A press gives one step immediately; holding the
//   button auto-repeats after HOLD_CYCLES, then every REPEAT_CYCLES. Pressing
//   both buttons locks out stepping until both are released.
//
// Ports
//   clk        rising-edge system clock
//   rst        synchronous active-high reset
//   btn_up     "count up" request level (debounced, synchronised)
//   btn_down   "count down" request level (debounced, synchronised)
//   EN         registered one-cycle step strobe to the counter
//   up         registered, high with EN on an up step
//   down       registered, high with EN on a down step
//   repeating  registered, high while a press is being held (HOLD/REPEAT)
module control_contador #(
  parameter int unsigned HOLD_CYCLES   = 50,
  parameter int unsigned REPEAT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic EN,
  output logic up,
  output logic down,
  output logic repeating
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

  state_t      state;
  logic        dir;    // 1 = up, 0 = down
  logic [15:0] timer;  // edges since the last step, zero-based

  logic        held;   // the latched button
  logic        other;  // the opposite button
  logic [15:0] last;   // terminal timer value for the current wait

  always_comb begin
    held  = dir ? btn_up   : btn_down;
    other = dir ? btn_down : btn_up;
    last  = (state == HOLD) ? HOLD_LAST : REP_LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      dir       <= 1'b1;
      EN        <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      repeating <= 1'b0;
    end else begin
      // Step outputs are strobes: cleared every cycle unless a step fires.
      EN   <= 1'b0;
      up   <= 1'b0;
      down <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_up && btn_down) begin
            state     <= LOCK;
            repeating <= 1'b0;
          end else if (btn_up || btn_down) begin
            state     <= HOLD;
            dir       <= btn_up;
            timer     <= '0;
            EN        <= 1'b1;
            up        <= btn_up;
            down      <= btn_down;
            repeating <= 1'b1;
          end else begin
            repeating <= 1'b0;
          end
        end
        HOLD, REPEAT: begin
          // Release wins over a simultaneous opposite press, so a clean
          // hand-over from one button to the other passes through IDLE and
          // steps the new direction on the following edge.
          if (!held) begin
            state     <= IDLE;
            repeating <= 1'b0;
          end else if (other) begin
            state     <= LOCK;
            repeating <= 1'b0;
          end else if (timer == last) begin
            state <= REPEAT;
            timer <= '0;
            EN    <= 1'b1;
            up    <= dir;
            down  <= ~dir;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        LOCK: begin
          repeating <= 1'b0;
          if (!btn_up && !btn_down) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          repeating <= 1'b0;
        end
      endcase
    end
  end

endmodule
